// File: rtl/solver_dispatch_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | solver_dispatch_pkg : state encoding and widths shared with the solver  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package solver_dispatch_pkg;

  localparam int          c_limb_index_bits = 6;
  localparam int          c_limb_bits       = 32;
  localparam int          c_tag_bits        = 8;
  localparam int          c_iter_bits       = 16;
  localparam logic [15:0] c_iter_limit_hit  = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_RUN    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/solver_dispatch_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | solver_dispatch_if : host stream, solver load/start bus and result port |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface solver_dispatch_if
  import solver_dispatch_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = c_limb_index_bits,
  parameter int LIMB_BITS       = c_limb_bits,
  parameter int TAG_BITS        = c_tag_bits
);

  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs;
  logic [c_iter_bits-1:0]     cfg_iter_lim;
  logic                       in_valid;
  logic                       in_ready;
  logic [LIMB_BITS-1:0]       in_re;
  logic [LIMB_BITS-1:0]       in_im;
  logic                       in_last;
  logic                       wr_en;
  logic [LIMB_INDEX_BITS-1:0] wr_ind;
  logic [LIMB_BITS-1:0]       wr_re_data;
  logic [LIMB_BITS-1:0]       wr_im_data;
  logic                       wr_num_limbs_en;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_data;
  logic                       wr_iter_lim_en;
  logic [c_iter_bits-1:0]     iter_lim_data;
  logic                       start;
  logic                       out_ready;
  logic [c_iter_bits-1:0]     iteration_count;
  logic                       res_valid;
  logic                       res_ready;
  logic [c_iter_bits-1:0]     res_count;
  logic [TAG_BITS-1:0]        res_tag;
  logic                       busy;
  logic                       proto_err;

  modport master (
    input  cfg_num_limbs, cfg_iter_lim, in_valid, in_re, in_im, in_last,
           out_ready, iteration_count, res_ready,
    output in_ready, wr_en, wr_ind, wr_re_data, wr_im_data, wr_num_limbs_en,
           num_limbs_data, wr_iter_lim_en, iter_lim_data, start,
           res_valid, res_count, res_tag, busy, proto_err
  );

  modport slave (
    output cfg_num_limbs, cfg_iter_lim, in_valid, in_re, in_im, in_last,
           out_ready, iteration_count, res_ready,
    input  in_ready, wr_en, wr_ind, wr_re_data, wr_im_data, wr_num_limbs_en,
           num_limbs_data, wr_iter_lim_en, iter_lim_data, start,
           res_valid, res_count, res_tag, busy, proto_err
  );

endinterface
`default_nettype wire

// File: rtl/solver_dispatch_result_slot.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | result_slot : one-entry valid/ready holding register                    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module result_slot #(
  parameter int WIDTH = 24
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_data,
  output logic                  o_can_load,
  output logic                  o_valid,
  input  wire logic             i_ready,
  output logic [WIDTH-1:0]      o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A load in the same cycle as a drain replaces the outgoing entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_can_load = ~r_valid | i_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;

endmodule
`default_nettype wire

// File: rtl/solver_dispatch.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | solver_dispatch : loads one point job into a solver, starts it and      |
// | returns the tagged iteration count.                 Rev 1.0             |
// +-------------------------------------------------------------------------+
module solver_dispatch
  import solver_dispatch_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = c_limb_index_bits,
  parameter int LIMB_BITS       = c_limb_bits,
  parameter int TAG_BITS        = c_tag_bits
) (
  input  wire logic          clock,
  input  wire logic          reset,
  solver_dispatch_if.master  bus
);

  state_t                     r_state;
  logic [LIMB_INDEX_BITS-1:0] r_idx;
  logic [1:0]                 r_hold;
  logic [TAG_BITS-1:0]        r_tag;
  logic                       r_in_ready;
  logic                       r_wr_en;
  logic [LIMB_INDEX_BITS-1:0] r_wr_ind;
  logic [LIMB_BITS-1:0]       r_wr_re;
  logic [LIMB_BITS-1:0]       r_wr_im;
  logic                       r_wr_nl_en;
  logic                       r_wr_il_en;
  logic [LIMB_INDEX_BITS-1:0] r_num_limbs;
  logic [c_iter_bits-1:0]     r_iter_lim;
  logic                       r_start;
  logic                       r_proto_err;

  logic                       w_beat;
  logic                       w_final;
  logic                       w_slot_free;
  logic                       w_capture;
  logic [TAG_BITS+c_iter_bits-1:0] w_slot_data;

  assign w_beat    = r_in_ready & bus.in_valid;
  assign w_final   = (r_idx == '0);
  // r_hold masks the stale out_ready during the start cycle and the one after it.
  assign w_capture = (r_state == ST_RUN) && (r_hold == 2'd0) && bus.out_ready && w_slot_free;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_hold      <= 2'd0;
      r_tag       <= '0;
      r_in_ready  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_ind    <= '0;
      r_wr_re     <= '0;
      r_wr_im     <= '0;
      r_wr_nl_en  <= 1'b0;
      r_wr_il_en  <= 1'b0;
      r_num_limbs <= '0;
      r_iter_lim  <= '0;
      r_start     <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_wr_nl_en <= 1'b0;
      r_wr_il_en <= 1'b0;
      r_start    <= 1'b0;

      if (w_beat) begin
        r_wr_en  <= 1'b1;
        r_wr_ind <= r_idx;
        r_wr_re  <= bus.in_re;
        r_wr_im  <= bus.in_im;
        if (bus.in_last != w_final) begin
          r_proto_err <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && (bus.cfg_num_limbs != '0)) begin
            r_num_limbs <= bus.cfg_num_limbs;
            r_iter_lim  <= bus.cfg_iter_lim;
            r_wr_nl_en  <= 1'b1;
            r_wr_il_en  <= 1'b1;
            r_state     <= ST_CONFIG;
          end
        end
        ST_CONFIG: begin
          r_idx      <= r_num_limbs - 1'b1;
          r_in_ready <= 1'b1;
          r_state    <= ST_LOAD;
        end
        ST_LOAD: begin
          if (w_beat) begin
            r_idx <= r_idx - 1'b1;
            if (w_final) begin
              r_in_ready <= 1'b0;
              r_state    <= ST_START;
            end
          end
        end
        ST_START: begin
          r_start <= 1'b1;
          r_hold  <= 2'd2;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (r_hold != 2'd0) begin
            r_hold <= r_hold - 2'd1;
          end else if (w_capture) begin
            r_tag   <= r_tag + 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  result_slot #(
    .WIDTH (TAG_BITS + c_iter_bits)
  ) u_result_slot (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_capture),
    .i_data     ({r_tag, bus.iteration_count}),
    .o_can_load (w_slot_free),
    .o_valid    (bus.res_valid),
    .i_ready    (bus.res_ready),
    .o_data     (w_slot_data)
  );

  assign bus.res_tag         = w_slot_data[TAG_BITS+c_iter_bits-1:c_iter_bits];
  assign bus.res_count       = w_slot_data[c_iter_bits-1:0];
  assign bus.in_ready        = r_in_ready;
  assign bus.wr_en           = r_wr_en;
  assign bus.wr_ind          = r_wr_ind;
  assign bus.wr_re_data      = r_wr_re;
  assign bus.wr_im_data      = r_wr_im;
  assign bus.wr_num_limbs_en = r_wr_nl_en;
  assign bus.num_limbs_data  = r_num_limbs;
  assign bus.wr_iter_lim_en  = r_wr_il_en;
  assign bus.iter_lim_data   = r_iter_lim;
  assign bus.start           = r_start;
  assign bus.busy            = (r_state != ST_IDLE);
  assign bus.proto_err       = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_solver_dispatch.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_solver_dispatch : random jobs against a queue-based job model        |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_solver_dispatch;
  import solver_dispatch_pkg::*;

  localparam int LIB = 6;
  localparam int LB  = 32;
  localparam int TB  = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  solver_dispatch_if #(.LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .TAG_BITS(TB)) bus ();

  solver_dispatch #(.LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .TAG_BITS(TB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Job model: what each job must produce, in issue order.
  logic [69:0] wq[$];    // {index, re, im} per write
  logic [21:0] cfgq[$];  // {num_limbs, iter_lim}
  logic [31:0] sq[$];    // {latency, count} for the solver model
  logic [23:0] rq[$];    // {tag, count} per result
  int   exp_tag  = 0;
  logic exp_perr = 1'b0;
  logic rr_rand  = 1'b0;

  // Output monitor.
  logic        p_wr_en, p_start, p_rv, p_rr;
  logic [15:0] p_cnt;
  logic [7:0]  p_tag;
  always @(negedge clock) begin
    logic [69:0] w;
    logic [21:0] c;
    logic [23:0] r;
    if (!reset) begin
      p_wr_en = 1'b0; p_start = 1'b0; p_rv = 1'b0; p_rr = 1'b0;
    end else begin
      if (bus.wr_num_limbs_en) begin
        check_eq("cfg_expected", cfgq.size() != 0, 1);
        check_eq("il_en", bus.wr_iter_lim_en, 1);
        if (cfgq.size() != 0) begin
          c = cfgq.pop_front();
          check_eq("num_limbs_data", bus.num_limbs_data, c[21:16]);
          check_eq("iter_lim_data", bus.iter_lim_data, c[15:0]);
        end
      end else begin
        check_eq("il_en_stray", bus.wr_iter_lim_en, 0);
      end
      if (bus.wr_en) begin
        check_eq("wr_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          check_eq("wr_ind", bus.wr_ind, w[69:64]);
          check_eq("wr_re", bus.wr_re_data, w[63:32]);
          check_eq("wr_im", bus.wr_im_data, w[31:0]);
        end
      end
      if (bus.start) begin
        check_eq("start_after_last_wr", p_wr_en, 1);
        check_eq("start_single", p_start, 0);
        check_eq("start_writes_done", wq.size(), 0);
      end
      if (p_rv && !p_rr) begin
        check_eq("res_hold_valid", bus.res_valid, 1);
        check_eq("res_hold_count", bus.res_count, p_cnt);
        check_eq("res_hold_tag", bus.res_tag, p_tag);
      end
      if (bus.res_valid && bus.res_ready) begin
        check_eq("res_expected", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          r = rq.pop_front();
          check_eq("res_count", bus.res_count, r[15:0]);
          check_eq("res_tag", bus.res_tag, r[23:16]);
        end
      end
      if (!bus.busy) check_eq("in_ready_idle", bus.in_ready, 0);
      p_wr_en = bus.wr_en; p_start = bus.start;
      p_rv = bus.res_valid; p_rr = bus.res_ready;
      p_cnt = bus.res_count; p_tag = bus.res_tag;
    end
  end

  // Solver model: out_ready stays stale-high for the start cycle and the next.
  initial begin
    logic [31:0] s;
    bus.out_ready       = 1'b1;
    bus.iteration_count = 16'hDEAD;
    forever begin
      @(negedge clock);
      if (reset && bus.start) begin
        check_eq("solver_job_expected", sq.size() != 0, 1);
        if (sq.size() != 0) begin
          s = sq.pop_front();
          @(posedge clock); #1;
          @(posedge clock); #1;
          bus.out_ready = 1'b0;
          repeat (s[31:16]) @(posedge clock);
          #1;
          bus.iteration_count = s[15:0];
          bus.out_ready       = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock); #1;
      if (rr_rand) bus.res_ready = 1'($urandom_range(1));
    end
  end

  task automatic run_job(input int n, input logic [15:0] lim, input logic [15:0] cnt,
                         input int lat, input int bad_pos, input int abort_after);
    int t;
    logic acc;
    logic [31:0] re, im;
    t = 0;
    do begin @(negedge clock); t++; end while (bus.busy && t < 3000);
    check_eq("idle_before_job", bus.busy, 0);
    cfgq.push_back({6'(n), lim});
    sq.push_back({16'(lat), cnt});
    rq.push_back({8'(exp_tag), cnt});
    exp_tag = (exp_tag + 1) % 256;
    if (bad_pos > 0 && bad_pos != n) exp_perr = 1'b1;
    bus.cfg_num_limbs = 6'(n);
    bus.cfg_iter_lim  = lim;
    for (int i = 0; i < n; i++) begin
      re = $urandom; im = $urandom;
      if ($urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_re    = re;
      bus.in_im    = im;
      bus.in_last  = (bad_pos > 0) ? (i == bad_pos - 1) : (i == n - 1);
      t = 0;
      do begin
        @(negedge clock); acc = bus.in_ready;
        @(posedge clock); #1; t++;
      end while (!acc && t < 200);
      check_eq("beat_accepted", acc, 1);
      wq.push_back({6'(n - 1 - i), re, im});
      if (i == 0) begin
        bus.cfg_num_limbs = 6'($urandom);
        bus.cfg_iter_lim  = 16'($urandom);
      end
      if (abort_after == i + 1) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drained();
    int t;
    t = 0;
    do begin @(negedge clock); t++; end while (rq.size() != 0 && t < 5000);
    check_eq("results_drained", rq.size(), 0);
  endtask

  initial begin
    int viol;
    bus.cfg_num_limbs = '0; bus.cfg_iter_lim = '0;
    bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.in_last = 1'b0;
    bus.res_ready = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_start", bus.start, 0);
    check_eq("rst_wr_en", bus.wr_en, 0);
    check_eq("rst_res_tag", bus.res_tag, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Basic job, immediate drain.
    run_job(4, 16'd100, 16'd37, 50, 0, 0);
    wait_drained();
    @(negedge clock);
    check_eq("busy_after_job", bus.busy, 0);

    // Result held unread while the next job loads; RUN stalls until drain.
    bus.res_ready = 1'b0;
    run_job(4, 16'd100, c_iter_limit_hit, 10, 0, 0);
    run_job(3, 16'd7, 16'd1234, 5, 0, 0);
    repeat (40) @(posedge clock);
    #1;
    check_eq("run_stalled", bus.busy, 1);
    check_eq("held_count", bus.res_count, c_iter_limit_hit);
    bus.res_ready = 1'b1;
    wait_drained();

    // in_last on beat 2 of 4.
    check_eq("perr_clean", bus.proto_err, 0);
    run_job(4, 16'd100, 16'd55, 8, 2, 0);
    wait_drained();
    check_eq("perr_set", bus.proto_err, exp_perr);

    // Random jobs with random result back-pressure, plus length extremes.
    rr_rand = 1'b1;
    for (int j = 0; j < 10; j++)
      run_job($urandom_range(1, 8), 16'($urandom), 16'($urandom), $urandom_range(1, 30), 0, 0);
    run_job(1, 16'd1, 16'd0, 3, 0, 0);
    run_job(63, 16'hFFFF, 16'd999, 4, 0, 0);
    rr_rand = 1'b0;
    #2 bus.res_ready = 1'b1;
    wait_drained();
    check_eq("perr_sticky", bus.proto_err, 1);

    // Zero limbs never starts a job.
    @(negedge clock);
    bus.cfg_num_limbs = '0;
    bus.in_valid = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clock);
      if (bus.in_ready | bus.start | bus.wr_en | bus.wr_num_limbs_en | bus.busy) viol++;
    end
    bus.in_valid = 1'b0;
    check_eq("zero_limbs_idle", viol, 0);

    // Reset in the middle of loading.
    run_job(4, 16'd100, 16'd77, 10, 0, 2);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_in_ready", bus.in_ready, 0);
    check_eq("mid_rst_wr_en", bus.wr_en, 0);
    check_eq("mid_rst_res_tag", bus.res_tag, 0);
    check_eq("mid_rst_res_count", bus.res_count, 0);
    check_eq("mid_rst_perr", bus.proto_err, 0);
    wq.delete(); cfgq.delete(); sq.delete(); rq.delete();
    exp_tag = 0; exp_perr = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    run_job(4, 16'd50, 16'd21, 12, 0, 0);
    wait_drained();

    check_eq("writes_left", wq.size(), 0);
    check_eq("cfg_left", cfgq.size(), 0);
    check_eq("perr_final", bus.proto_err, exp_perr);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/solver_dispatch.md
Name: solver_dispatch

Overview:
- Host-side driver for solver_control and its datapath: the initiator end of the load/start/out_ready protocol.
- Accepts one point job as a stream of c limbs, programs limb count and iteration limit, writes c_re/c_im limb by limb, pulses start, waits for out_ready.
- Returns iteration_count with a job tag on a valid/ready result port.
- Sits between the host bus adapter and one solver instance.

Parameters:
LIMB_INDEX_BITS, 6, width of limb index and limb count
LIMB_BITS, 32, width of one c limb
TAG_BITS, 8, width of job tag

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
cfg_num_limbs  in  LIMB_INDEX_BITS  limbs per number (host register)
cfg_iter_lim  in  16  iteration limit (host register)
in_valid  in  1  c limb beat valid
in_ready  out  1  c limb beat accepted
in_re  in  LIMB_BITS  c_re limb
in_im  in  LIMB_BITS  c_im limb
in_last  in  1  host marks final limb of job
wr_en  out  1  to solver: write c limb
wr_ind  out  LIMB_INDEX_BITS  to solver: limb index of write
wr_re_data  out  LIMB_BITS  c_re limb data
wr_im_data  out  LIMB_BITS  c_im limb data
wr_num_limbs_en  out  1  load num_limbs
num_limbs_data  out  LIMB_INDEX_BITS  num_limbs value
wr_iter_lim_en  out  1  load iteration limit
iter_lim_data  out  16  iteration limit value
start  out  1  one-cycle start pulse
out_ready  in  1  from solver: result valid / solver idle
iteration_count  in  16  from solver: result; 16'hFFFF means limit reached
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_count  out  16  captured iteration_count
res_tag  out  TAG_BITS  tag of job
busy  out  1  job in flight (state != IDLE)
proto_err  out  1  sticky in_last mismatch

Behaviour:
- Reset values (async, while reset==0): state IDLE, all solver strobes 0, start 0, in_ready 0, res_valid 0, res_count 0, res_tag 0, tag counter 0, proto_err 0, busy 0.
- Registered outputs: start, wr_*, and their data buses.
- IDLE:
  - in_ready 0.
  - If in_valid and cfg_num_limbs != 0, latch cfg_num_limbs into n and cfg_iter_lim into lim, then go to CONFIG.
  - cfg_num_limbs == 0: remain IDLE, never start.
- CONFIG (1 cycle): wr_num_limbs_en=1, wr_iter_lim_en=1, num_limbs_data=n, iter_lim_data=lim; set idx=n-1; go to LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted beat (in_valid & in_ready) produces wr_en=1, wr_ind=idx, wr_re_data=in_re, wr_im_data=in_im on the next cycle. Limbs arrive most-significant first.
  - idx decrements per beat. The beat accepted at idx==0 is final: go to START.
  - in_last must be 1 on the final beat and only on it. Any mismatch sets proto_err, which is cleared only by reset.
  - Beat counting always follows n; in_last never truncates or extends a job.
- START (1 cycle): start=1, after the final wr_en has been issued. Go to RUN.
- RUN:
  - out_ready is ignored in the cycle start is high, and in the cycle immediately following it.
  - After that, when out_ready==1 and res_valid==0: capture res_count=iteration_count, res_tag=tag; set res_valid=1; increment tag (wraps mod 2^TAG_BITS); go to IDLE.
  - If out_ready==1 while res_valid==1, stay in RUN until the result slot frees. The solver holds its count while in LOAD.
- Result port:
  - res_valid holds with stable data until res_ready is sampled high.
  - Capture and drain in the same cycle is allowed: the old result drains and the new one loads.
- Next job may be loaded while the previous result is unread.
- cfg_* changes outside IDLE have no effect on the current job.
- Reset mid-job: everything returns to reset values. The solver is reset on the same reset tree, so no recovery handshake is needed.

Decomposition:
- Shared package: state encoding (IDLE, CONFIG, LOAD, START, RUN), ITER_LIMIT_HIT=16'hFFFF, and widths shared with solver_control.
- Sub-module: result_slot, a one-entry valid/ready holding register for {res_tag, res_count}.

Test Plan:
- num_limbs=4, iter_lim=100, 4 beats with in_last on beat 4 -> one cycle with both config strobes; wr_ind sequence 3,2,1,0 with matching data; start pulses once, one cycle after the last wr_en.
- Solver model raises out_ready with count 37 after 50 cycles, res_ready=1 -> res_valid pulses with res_count=37, res_tag=0; busy drops.
- Same job with count 16'hFFFF while res_ready=0 for 20 cycles -> res_valid and data stable throughout; second job's limbs accepted meanwhile; RUN stalls until the drain, then the result appears with tag 2.
- in_last on beat 2 of 4 -> proto_err=1 (sticky); 4 writes are still issued and start still pulses.
- cfg_num_limbs=0 with in_valid=1 -> in_ready, start and all wr strobes stay 0 for 100 cycles.
- reset=0 during LOAD after 2 beats -> all outputs return to reset values immediately; after release, a fresh 4-beat job completes normally with tag 0.
